// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_e;

  localparam int REG_ADDR_W_DEF = 5;
  localparam int INIT_CNT_W     = 8;
  localparam int WAIT_CNT_W     = 8;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic mem_wb_flush;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_RUN = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1,
                                    ex_mem_en: 1'b1, mem_wb_en: 1'b1,
                                    if_id_flush: 1'b0, id_ex_flush: 1'b0,
                                    ex_mem_flush: 1'b0, mem_wb_flush: 1'b0};

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. Perf counter outputs exist
// only when HAZARD_PERF_CNT_EN is defined.
interface hazard_ctrl_if #(
  parameter int REG_ADDR_W = hazard_pkg::REG_ADDR_W_DEF
);
  logic [REG_ADDR_W-1:0] ID_RS1;
  logic [REG_ADDR_W-1:0] ID_RS2;
  logic                  ID_USES_RS1;
  logic                  ID_USES_RS2;
  logic [REG_ADDR_W-1:0] EX_RD;
  logic                  EX_RF_WE;
  logic                  EX_IS_LOAD;
  logic                  EX_BRANCH_TAKEN;
  logic                  MEM_DM_REQ;
  logic                  DM_READY;
  logic                  PC_EN;
  logic                  IF_ID_EN;
  logic                  ID_EX_EN;
  logic                  EX_MEM_EN;
  logic                  MEM_WB_EN;
  logic                  IF_ID_FLUSH;
  logic                  ID_EX_FLUSH;
  logic                  EX_MEM_FLUSH;
  logic                  MEM_WB_FLUSH;
  logic                  DM_ERR;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]           STALL_CNT;
  logic [31:0]           FLUSH_CNT;
`endif

  modport master (
`ifdef HAZARD_PERF_CNT_EN
    input  STALL_CNT, FLUSH_CNT,
`endif
    output ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2, EX_RD, EX_RF_WE,
           EX_IS_LOAD, EX_BRANCH_TAKEN, MEM_DM_REQ, DM_READY,
    input  PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN,
           IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH, MEM_WB_FLUSH, DM_ERR
  );

  modport slave (
`ifdef HAZARD_PERF_CNT_EN
    output STALL_CNT, FLUSH_CNT,
`endif
    input  ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2, EX_RD, EX_RF_WE,
           EX_IS_LOAD, EX_BRANCH_TAKEN, MEM_DM_REQ, DM_READY,
    output PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN,
           IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH, MEM_WB_FLUSH, DM_ERR
  );

endinterface

// File: rtl/haz_match.sv
// Load-use comparator: flags an ID source that reads the register a load in EX
// is about to write. Register 0 never matches.
module haz_match
  import hazard_pkg::*;
#(
  parameter int W = REG_ADDR_W_DEF
) (
  input  logic [W-1:0] rs1_i,
  input  logic [W-1:0] rs2_i,
  input  logic         uses_rs1_i,
  input  logic         uses_rs2_i,
  input  logic [W-1:0] rd_i,
  input  logic         rf_we_i,
  input  logic         is_load_i,
  output logic         hazard_o
);

  logic [1:0][W-1:0] src;
  logic [1:0]        uses;
  logic [1:0]        src_hit;

  assign src  = {rs2_i, rs1_i};
  assign uses = {uses_rs2_i, uses_rs1_i};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = uses[gi] && (src[gi] == rd_i);
    end
  endgenerate

  assign hazard_o = is_load_i && rf_we_i && (rd_i != '0) && (|src_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: post-reset flush, load-use stall, branch flush
// and data-memory wait with timeout. HAZARD_PERF_CNT_EN adds stall/flush counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int INIT_CYCLES = 3,
  parameter int DM_TIMEOUT  = 16
) (
  input  logic            clk,
  input  logic            rst,
  hazard_ctrl_if.slave    hz
);

  hz_state_e               state_q, state_d;
  logic [INIT_CNT_W-1:0]   init_cnt_q, init_cnt_d;
  logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                    dm_err_q, dm_err_d;
  logic                    load_use;
  logic                    mem_stall;
  logic                    wait_timeout;
  hz_ctrl_t                ctrl;

  haz_match #(.W(REG_ADDR_W)) u_match (
    .rs1_i      (hz.ID_RS1),
    .rs2_i      (hz.ID_RS2),
    .uses_rs1_i (hz.ID_USES_RS1),
    .uses_rs2_i (hz.ID_USES_RS2),
    .rd_i       (hz.EX_RD),
    .rf_we_i    (hz.EX_RF_WE),
    .is_load_i  (hz.EX_IS_LOAD),
    .hazard_o   (load_use)
  );

  assign mem_stall    = hz.MEM_DM_REQ && !hz.DM_READY;
  assign wait_timeout = (wait_cnt_q == WAIT_CNT_W'(DM_TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      wait_cnt_q <= '0;
      dm_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      dm_err_q   <= dm_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    wait_cnt_d = wait_cnt_q;
    dm_err_d   = dm_err_q;
    case (state_q)
      INIT: begin
        if (init_cnt_q == INIT_CNT_W'(INIT_CYCLES - 1)) begin
          state_d    = RUN;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + INIT_CNT_W'(1);
        end
      end
      RUN: begin
        if (mem_stall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (hz.DM_READY) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_timeout) begin
          // Abandon the access; the pipeline resumes and the error stays latched.
          dm_err_d   = 1'b1;
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    ctrl = CTRL_RUN;
    case (state_q)
      INIT: begin
        ctrl.pc_en        = 1'b0;
        ctrl.if_id_flush  = 1'b1;
        ctrl.id_ex_flush  = 1'b1;
        ctrl.ex_mem_flush = 1'b1;
        ctrl.mem_wb_flush = 1'b1;
      end
      RUN: begin
        if (mem_stall) begin
          ctrl.pc_en        = 1'b0;
          ctrl.if_id_en     = 1'b0;
          ctrl.id_ex_en     = 1'b0;
          ctrl.ex_mem_en    = 1'b0;
          ctrl.mem_wb_flush = 1'b1;
        end else if (hz.EX_BRANCH_TAKEN) begin
          // A taken branch kills the dependent instruction, so no stall is needed.
          ctrl.if_id_flush = 1'b1;
          ctrl.id_ex_flush = 1'b1;
        end else if (load_use) begin
          ctrl.pc_en       = 1'b0;
          ctrl.if_id_en    = 1'b0;
          ctrl.id_ex_flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!hz.DM_READY && !wait_timeout) begin
          ctrl.pc_en        = 1'b0;
          ctrl.if_id_en     = 1'b0;
          ctrl.id_ex_en     = 1'b0;
          ctrl.ex_mem_en    = 1'b0;
          ctrl.mem_wb_flush = 1'b1;
        end
      end
      default: ctrl = CTRL_RUN;
    endcase
  end

  assign hz.PC_EN        = ctrl.pc_en;
  assign hz.IF_ID_EN     = ctrl.if_id_en;
  assign hz.ID_EX_EN     = ctrl.id_ex_en;
  assign hz.EX_MEM_EN    = ctrl.ex_mem_en;
  assign hz.MEM_WB_EN    = ctrl.mem_wb_en;
  assign hz.IF_ID_FLUSH  = ctrl.if_id_flush;
  assign hz.ID_EX_FLUSH  = ctrl.id_ex_flush;
  assign hz.EX_MEM_FLUSH = ctrl.ex_mem_flush;
  assign hz.MEM_WB_FLUSH = ctrl.mem_wb_flush;
  assign hz.DM_ERR       = dm_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((state_q != INIT) && !ctrl.pc_en && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if ((state_q == RUN) && ctrl.if_id_flush && (flush_cnt_q != 32'hFFFF_FFFF))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign hz.STALL_CNT = stall_cnt_q;
  assign hz.FLUSH_CNT = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: fixed vectors, multi-cycle corner sequences and a
// randomized run against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int  INIT_CYCLES = 3;
  localparam int  DM_TIMEOUT  = 16;
  // {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id, id_ex, ex_mem, mem_wb flushes, dm_err}
  localparam logic [9:0] O_INIT  = 10'b0111111110;
  localparam logic [9:0] O_RUN   = 10'b1111100000;
  localparam logic [9:0] O_STALL = 10'b0011101000;
  localparam logic [9:0] O_BR    = 10'b1111111000;
  localparam logic [9:0] O_FRZ   = 10'b0000100010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc_n = 0;

  int   m_init_left;
  bit   m_waiting;
  int   m_waited;
  bit   m_err;
  int   m_stall;
  int   m_flush;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_ADDR_W(5)) hz_if ();

  hazard_ctrl #(
    .REG_ADDR_W (5),
    .INIT_CYCLES(INIT_CYCLES),
    .DM_TIMEOUT (DM_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz_if)
  );

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    bit         u1;
    bit         u2;
    logic [4:0] rd;
    bit         we;
    bit         ld;
    bit         br;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[10];

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input bit u1,
                        input bit u2, input logic [4:0] rd, input bit we, input bit ld,
                        input bit br, input bit req, input bit rdy);
    hz_if.ID_RS1          = rs1;
    hz_if.ID_RS2          = rs2;
    hz_if.ID_USES_RS1     = u1;
    hz_if.ID_USES_RS2     = u2;
    hz_if.EX_RD           = rd;
    hz_if.EX_RF_WE        = we;
    hz_if.EX_IS_LOAD      = ld;
    hz_if.EX_BRANCH_TAKEN = br;
    hz_if.MEM_DM_REQ      = req;
    hz_if.DM_READY        = rdy;
  endtask

  function automatic logic [9:0] dut_vec();
    return {hz_if.PC_EN, hz_if.IF_ID_EN, hz_if.ID_EX_EN, hz_if.EX_MEM_EN, hz_if.MEM_WB_EN,
            hz_if.IF_ID_FLUSH, hz_if.ID_EX_FLUSH, hz_if.EX_MEM_FLUSH, hz_if.MEM_WB_FLUSH,
            hz_if.DM_ERR};
  endfunction

  function automatic void model_reset();
    m_init_left = INIT_CYCLES;
    m_waiting   = 1'b0;
    m_waited    = 0;
    m_err       = 1'b0;
    m_stall     = 0;
    m_flush     = 0;
  endfunction

  function automatic bit model_freeze();
    if (m_init_left > 0) return 1'b0;
    if (m_waiting) return !hz_if.DM_READY && (m_waited < DM_TIMEOUT);
    return hz_if.MEM_DM_REQ && !hz_if.DM_READY;
  endfunction

  function automatic bit model_load_use();
    bit hit1, hit2;
    hit1 = hz_if.ID_USES_RS1 && (int'(hz_if.ID_RS1) == int'(hz_if.EX_RD));
    hit2 = hz_if.ID_USES_RS2 && (int'(hz_if.ID_RS2) == int'(hz_if.EX_RD));
    return hz_if.EX_IS_LOAD && hz_if.EX_RF_WE && (int'(hz_if.EX_RD) != 0) && (hit1 || hit2);
  endfunction

  function automatic logic [9:0] model_out();
    if (m_init_left > 0) return O_INIT | 10'(m_err);
    if (model_freeze())  return O_FRZ | 10'(m_err);
    if (m_waiting)       return O_RUN | 10'(m_err);
    if (hz_if.EX_BRANCH_TAKEN) return O_BR | 10'(m_err);
    if (model_load_use())      return O_STALL | 10'(m_err);
    return O_RUN | 10'(m_err);
  endfunction

  function automatic void model_step();
    logic [9:0] o;
    if (rst) begin
      model_reset();
      return;
    end
    o = model_out();
    if (m_init_left > 0) begin
      m_init_left--;
    end else begin
      if (!o[9]) m_stall++;
      if (!m_waiting && o[4]) m_flush++;
      if (model_freeze()) begin
        m_waiting = 1'b1;
        m_waited++;
      end else if (m_waiting) begin
        if (!hz_if.DM_READY) m_err = 1'b1;
        m_waiting = 1'b0;
        m_waited  = 0;
      end
    end
  endfunction

  task automatic check10(input string name, input logic [9:0] act, input logic [9:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // One clock cycle: inputs already driven, compare mid-cycle, then advance model at the edge.
  task automatic cyc(input logic [9:0] exp, input bit use_exp, input string name);
    logic [9:0] act;
    logic [9:0] mo;
    if (rst) model_reset();
    #3;
    act = dut_vec();
    mo  = model_out();
    check10({name, "/model"}, act, mo);
    if (use_exp) check10(name, act, exp);
    total++;
    if ((act[4] && !act[8]) || (act[3] && !act[7]) || (act[2] && !act[6]) || (act[1] && !act[5])) begin
      bad++;
      $display("FAIL %s/flush_en: flush without enable, outputs %b", name, act);
    end
`ifdef HAZARD_PERF_CNT_EN
    total++;
    if (hz_if.STALL_CNT !== 32'(m_stall) || hz_if.FLUSH_CNT !== 32'(m_flush)) begin
      bad++;
      $display("FAIL %s/perf: stall=%0d flush=%0d expected %0d %0d", name,
               hz_if.STALL_CNT, hz_if.FLUSH_CNT, m_stall, m_flush);
    end
`endif
    $display("cyc %0d %s rst=%0b out=%b", cyc_n, name, rst, act);
    cyc_n++;
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    model_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[0] = '{5'd1, 5'd2, 1, 1, 5'd3, 1, 1, 0, O_RUN};
    tbl[1] = '{5'd1, 5'd5, 0, 1, 5'd5, 1, 1, 0, O_STALL};
    tbl[2] = '{5'd0, 5'd0, 1, 1, 5'd0, 1, 1, 0, O_RUN};
    tbl[3] = '{5'd1, 5'd5, 1, 0, 5'd5, 1, 1, 0, O_RUN};
    tbl[4] = '{5'd7, 5'd2, 1, 0, 5'd7, 1, 1, 0, O_STALL};
    tbl[5] = '{5'd5, 5'd5, 1, 1, 5'd5, 1, 0, 0, O_RUN};
    tbl[6] = '{5'd5, 5'd5, 1, 1, 5'd5, 0, 1, 0, O_RUN};
    tbl[7] = '{5'd1, 5'd2, 1, 1, 5'd9, 1, 0, 1, O_BR};
    tbl[8] = '{5'd4, 5'd9, 1, 1, 5'd4, 1, 1, 1, O_BR};
    tbl[9] = '{5'd31, 5'd31, 1, 1, 5'd31, 1, 1, 0, O_STALL};

    repeat (2) @(posedge clk);
    #1;
    cyc(O_INIT, 1, "rst_hold");
    rst = 1'b0;
    for (int i = 0; i < INIT_CYCLES; i++) cyc(O_INIT, 1, $sformatf("init%0d", i + 1));
    cyc(O_RUN, 1, "run_first");

    // Load-use: one bubble, then the bubbled EX no longer matches
    set_in(5'd1, 5'd5, 0, 1, 5'd5, 1, 1, 0, 0, 1);
    cyc(O_STALL, 1, "ld_use_rs2");
    set_in(5'd1, 5'd5, 0, 1, 5'd0, 0, 0, 0, 0, 1);
    cyc(O_RUN, 1, "ld_use_bubble");
    set_in(5'd0, 5'd0, 1, 1, 5'd0, 1, 1, 0, 0, 1);
    cyc(O_RUN, 1, "ld_rd0");

    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(O_FRZ, 1, $sformatf("dm_wait%0d", i + 1));
    hz_if.DM_READY = 1'b1;
    cyc(O_RUN, 1, "dm_release");
    hz_if.MEM_DM_REQ = 1'b0;
    cyc(O_RUN, 1, "dm_after");
`ifdef HAZARD_PERF_CNT_EN
    check10("perf_stall5", hz_if.STALL_CNT[9:0], 10'd5);
    check10("perf_flush0", hz_if.FLUSH_CNT[9:0], 10'd0);
`endif

    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].rd,
             tbl[i].we, tbl[i].ld, tbl[i].br, 0, 1);
      cyc(tbl[i].exp, 1, $sformatf("vec%0d", i));
    end

    // Timeout: 16 freeze cycles, one abandon cycle, then sticky error
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < DM_TIMEOUT; i++) cyc(O_FRZ, 1, $sformatf("to_wait%0d", i + 1));
    cyc(O_RUN, 1, "to_abandon");
    hz_if.MEM_DM_REQ = 1'b0;
    for (int i = 0; i < 3; i++) cyc(O_RUN | 10'd1, 1, $sformatf("err_sticky%0d", i));

    // Reset in the middle of a wait clears everything and restarts INIT
    hz_if.MEM_DM_REQ = 1'b1;
    cyc(O_FRZ | 10'd1, 1, "mw_wait1");
    cyc(O_FRZ | 10'd1, 1, "mw_wait2");
    rst = 1'b1;
    cyc(O_INIT, 1, "mw_rst");
`ifdef HAZARD_PERF_CNT_EN
    check10("perf_rst_stall", hz_if.STALL_CNT[9:0], 10'd0);
    check10("perf_rst_flush", hz_if.FLUSH_CNT[9:0], 10'd0);
`endif
    rst = 1'b0;
    for (int i = 0; i < INIT_CYCLES; i++) cyc(O_INIT, 1, $sformatf("mw_init%0d", i + 1));
    hz_if.MEM_DM_REQ = 1'b0;
    cyc(O_RUN, 1, "mw_run");

    for (int i = 0; i < 600; i++) begin
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
             bit'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 3) == 0),
             (i < 300) ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 12) == 0));
      rst = (i == 450);
      cyc(10'd0, 0, "rnd");
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
